// File: rtl/bsg_popcount_accum.sv
`default_nettype none
// ============================================================================
//  Module      : bsg_popcount_accum
//  Description : Pipelined, packetised popcount accumulator. Stage 1 registers
//                per-chunk popcounts of each accepted beat; stage 2 sums them
//                into saturating per-packet bit/beat totals and emits one
//                result per packet over a valid/ready output.
//  Revision    : 1.0 - initial release
// ============================================================================
module bsg_popcount_accum #(
  parameter int width_p      = 64,
  parameter int chunk_p      = 8,
  parameter int sum_width_p  = 16,
  parameter int beat_width_p = 8
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    v_i,
  input  logic [width_p-1:0]      data_i,
  input  logic                    last_i,
  output logic                    ready_o,
  output logic                    v_o,
  output logic [sum_width_p-1:0]  sum_o,
  output logic [beat_width_p-1:0] beats_o,
  output logic                    sat_o,
  input  logic                    ready_i
);

  localparam int c_nchunk = (width_p + chunk_p - 1) / chunk_p;
  localparam int c_padw   = c_nchunk * chunk_p;
  localparam int c_cw     = $clog2(chunk_p + 1);
  localparam int c_pcw    = $clog2(width_p + 1);
  localparam int c_sw1    = sum_width_p + 1;
  localparam int c_bw1    = beat_width_p + 1;

  // Stage 1 state
  logic                       r_s1_v;
  logic                       r_s1_last;
  logic [c_nchunk*c_cw-1:0]   r_s1_pc;

  // Stage 2 accumulators
  logic [sum_width_p-1:0]     r_acc_sum;
  logic [beat_width_p-1:0]    r_acc_beat;
  logic                       r_sat_acc;

  // Output registers
  logic                       r_v_o;
  logic [sum_width_p-1:0]     r_sum_o;
  logic [beat_width_p-1:0]    r_beats_o;
  logic                       r_sat_o;

  logic [c_padw-1:0]          w_pad;
  logic [c_nchunk*c_cw-1:0]   w_cnt;
  logic [c_pcw-1:0]           w_pc;
  logic [sum_width_p:0]       w_sum_ext;
  logic [beat_width_p:0]      w_beat_ext;
  logic [sum_width_p-1:0]     w_nsum;
  logic [beat_width_p-1:0]    w_nbeat;
  logic                       w_nsat;
  logic                       w_s1_adv;

  // Zero-extend the beat to a whole number of chunks so the last chunk
  // can be narrower than chunk_p without special-case indexing.
  always_comb begin
    w_pad                = '0;
    w_pad[width_p-1:0]   = data_i;
  end

  // Per-chunk popcount of the incoming beat
  always_comb begin
    w_cnt = '0;
    for (int c = 0; c < c_nchunk; c++) begin
      for (int b = 0; b < chunk_p; b++) begin
        w_cnt[c*c_cw +: c_cw] = w_cnt[c*c_cw +: c_cw] + c_cw'(w_pad[c*chunk_p + b]);
      end
    end
  end

  // Beat total from the registered chunk counts
  always_comb begin
    w_pc = '0;
    for (int c = 0; c < c_nchunk; c++) begin
      w_pc = w_pc + c_pcw'(r_s1_pc[c*c_cw +: c_cw]);
    end
  end

  // One spare MSB on each sum detects the clamp condition.
  assign w_sum_ext  = {1'b0, r_acc_sum} + c_sw1'(w_pc);
  assign w_beat_ext = {1'b0, r_acc_beat} + c_bw1'(1);
  assign w_nsum     = w_sum_ext[sum_width_p]   ? '1 : w_sum_ext[sum_width_p-1:0];
  assign w_nbeat    = w_beat_ext[beat_width_p] ? '1 : w_beat_ext[beat_width_p-1:0];
  assign w_nsat     = r_sat_acc | w_sum_ext[sum_width_p] | w_beat_ext[beat_width_p];

  // Only a last beat that would overwrite an unconsumed result stalls.
  assign w_s1_adv = r_s1_v & ~(r_s1_last & r_v_o & ~ready_i);
  assign ready_o  = ~r_s1_v | w_s1_adv;

  // Stage 1: capture chunk counts of the accepted beat, bubble when idle
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_s1_v    <= 1'b0;
      r_s1_last <= 1'b0;
      r_s1_pc   <= '0;
    end else if (ready_o) begin
      r_s1_v <= v_i;
      if (v_i) begin
        r_s1_pc   <= w_cnt;
        r_s1_last <= last_i;
      end
    end
  end

  // Stage 2: accumulate, and restart cleanly after the last beat of a packet
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_acc_sum  <= '0;
      r_acc_beat <= '0;
      r_sat_acc  <= 1'b0;
    end else if (w_s1_adv) begin
      if (r_s1_last) begin
        r_acc_sum  <= '0;
        r_acc_beat <= '0;
        r_sat_acc  <= 1'b0;
      end else begin
        r_acc_sum  <= w_nsum;
        r_acc_beat <= w_nbeat;
        r_sat_acc  <= w_nsat;
      end
    end
  end

  // Output register: load on packet end, drop valid once consumed
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_v_o     <= 1'b0;
      r_sum_o   <= '0;
      r_beats_o <= '0;
      r_sat_o   <= 1'b0;
    end else if (w_s1_adv && r_s1_last) begin
      r_v_o     <= 1'b1;
      r_sum_o   <= w_nsum;
      r_beats_o <= w_nbeat;
      r_sat_o   <= w_nsat;
    end else if (ready_i) begin
      r_v_o     <= 1'b0;
    end
  end

  assign v_o     = r_v_o;
  assign sum_o   = r_sum_o;
  assign beats_o = r_beats_o;
  assign sat_o   = r_sat_o;

`ifndef SYNTHESIS
  if (sum_width_p < c_pcw) begin : g_bad_sum_width
    $error("bsg_popcount_accum: sum_width_p cannot hold a full-beat popcount");
  end

  // Handshake inputs must be known whenever the block is out of reset
  always @(posedge clk_i) begin
    if (!reset_i) begin
      assert (!$isunknown(v_i));
      assert (!$isunknown(ready_i));
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_bsg_popcount_accum.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bsg_popcount_accum
//  Description : Self-checking bench. Three instances share stimulus:
//                64-bit/16-bit sum (a), 64-bit/8-bit sum (b, saturates) and
//                13-bit data/3-bit beat count (c, partial chunk, beat clamp).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bsg_popcount_accum;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        v_i = 1'b0;
  logic [63:0] data = '0;
  logic        last = 1'b0;
  logic        ready_i = 1'b1;

  logic        rdy_a, rdy_b, rdy_c;
  logic        vo_a, vo_b, vo_c;
  logic [15:0] sum_a;
  logic [7:0]  sum_b;
  logic [15:0] sum_c;
  logic [7:0]  beats_a, beats_b;
  logic [2:0]  beats_c;
  logic        sat_a, sat_b, sat_c;

  always #5 clk = ~clk;

  bsg_popcount_accum #(.width_p(64), .chunk_p(8), .sum_width_p(16), .beat_width_p(8)) u_dut (
    .clk_i(clk), .reset_i(rst), .v_i(v_i), .data_i(data), .last_i(last), .ready_o(rdy_a),
    .v_o(vo_a), .sum_o(sum_a), .beats_o(beats_a), .sat_o(sat_a), .ready_i(ready_i));

  bsg_popcount_accum #(.width_p(64), .chunk_p(8), .sum_width_p(8), .beat_width_p(8)) u_sat (
    .clk_i(clk), .reset_i(rst), .v_i(v_i), .data_i(data), .last_i(last), .ready_o(rdy_b),
    .v_o(vo_b), .sum_o(sum_b), .beats_o(beats_b), .sat_o(sat_b), .ready_i(ready_i));

  bsg_popcount_accum #(.width_p(13), .chunk_p(8), .sum_width_p(16), .beat_width_p(3)) u_nar (
    .clk_i(clk), .reset_i(rst), .v_i(v_i), .data_i(data[12:0]), .last_i(last), .ready_o(rdy_c),
    .v_o(vo_c), .sum_o(sum_c), .beats_o(beats_c), .sat_o(sat_c), .ready_i(ready_i));

  int total = 0;
  int bad   = 0;

  task automatic check(input string nm, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  // ---------------- reference model: packet totals in plain integers -------
  typedef struct {
    int s64;
    int s13;
    int n;
  } pkt_t;

  pkt_t q[$];
  int   acc64 = 0, acc13 = 0, accn = 0;
  int   n_consumed = 0;
  int   cap_sum_a, cap_beats_a, cap_sat_a, cap_sum_b, cap_sat_b, cap_sum_c, cap_beats_c, cap_sat_c;
  bit   hold_pending = 0;
  int   p_sum_a, p_beats_a, p_sat_a, p_sum_b;

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      acc64 = 0; acc13 = 0; accn = 0;
      hold_pending = 0;
    end else begin
      if (hold_pending) begin
        check("hold_v", vo_a, 1);
        check("hold_sum", sum_a, p_sum_a);
        check("hold_beats", beats_a, p_beats_a);
        check("hold_sat", sat_a, p_sat_a);
        check("hold_sum_b", sum_b, p_sum_b);
      end
      hold_pending = vo_a && !ready_i;
      p_sum_a = sum_a; p_beats_a = beats_a; p_sat_a = sat_a; p_sum_b = sum_b;

      if (vo_a && ready_i) begin
        pkt_t e;
        check("v_b_agrees", vo_b, 1);
        check("v_c_agrees", vo_c, 1);
        if (q.size() == 0) begin
          check("unexpected_result", 1, 0);
        end else begin
          e = q.pop_front();
          check("sb_sum_a",   sum_a,   imin(e.s64, 65535));
          check("sb_beats_a", beats_a, imin(e.n, 255));
          check("sb_sat_a",   sat_a,   (e.s64 > 65535 || e.n > 255) ? 1 : 0);
          check("sb_sum_b",   sum_b,   imin(e.s64, 255));
          check("sb_beats_b", beats_b, imin(e.n, 255));
          check("sb_sat_b",   sat_b,   (e.s64 > 255 || e.n > 255) ? 1 : 0);
          check("sb_sum_c",   sum_c,   e.s13);
          check("sb_beats_c", beats_c, imin(e.n, 7));
          check("sb_sat_c",   sat_c,   (e.n > 7) ? 1 : 0);
        end
        cap_sum_a = sum_a; cap_beats_a = beats_a; cap_sat_a = sat_a;
        cap_sum_b = sum_b; cap_sat_b = sat_b;
        cap_sum_c = sum_c; cap_beats_c = beats_c; cap_sat_c = sat_c;
        n_consumed++;
      end

      if (v_i && rdy_a) begin
        acc64 += $countones(data);
        acc13 += $countones(data[12:0]);
        accn  += 1;
        if (last) begin
          q.push_back('{s64: acc64, s13: acc13, n: accn});
          acc64 = 0; acc13 = 0; accn = 0;
        end
      end
    end
  end

  // ---------------- stimulus helpers --------------------------------------
  task automatic send_beat(input logic [63:0] d, input logic l);
    int t = 0;
    v_i = 1'b1; data = d; last = l;
    @(negedge clk);
    while (!rdy_a && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("accept_in_time", rdy_a, 1);
    @(posedge clk); #1;
    v_i = 1'b0; last = 1'b0; data = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_result(input int target);
    int t = 0;
    while (n_consumed < target && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    check("result_in_time", n_consumed, target);
  endtask

  bit rand_rdy = 0;
  initial forever begin
    @(posedge clk); #1;
    if (rand_rdy) ready_i = ($urandom_range(0, 2) != 0);
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  // ---------------- directed table ---------------------------------------
  typedef struct packed {
    int              nb;
    logic [4:0][63:0] d;
    logic [4:0][3:0]  gaps;
    int              es;
    int              eb;
    int              esat;
    int              es8;
    int              esat8;
  } vec_t;

  vec_t tbl [6];

  initial begin
    int c0;
    logic [63:0] ones;
    ones = '1;

    tbl[0] = '{nb: 4, d: {64'h0, 64'h8000_0000_0000_0001, 64'h1, 64'h0, ones},
               gaps: 20'h0, es: 67, eb: 4, esat: 0, es8: 67, esat8: 0};
    tbl[1] = '{nb: 3, d: {64'h0, 64'h0, 64'd3, 64'd3, 64'd3},
               gaps: {4'd0, 4'd0, 4'd0, 4'd1, 4'd3}, es: 6, eb: 3, esat: 0, es8: 6, esat8: 0};
    tbl[2] = '{nb: 1, d: {64'h0, 64'h0, 64'h0, 64'h0, 64'h0},
               gaps: 20'h0, es: 0, eb: 1, esat: 0, es8: 0, esat8: 0};
    tbl[3] = '{nb: 5, d: {ones, ones, ones, ones, ones},
               gaps: 20'h0, es: 320, eb: 5, esat: 0, es8: 255, esat8: 1};
    tbl[4] = '{nb: 1, d: {64'h0, 64'h0, 64'h0, 64'h0, 64'h1},
               gaps: 20'h0, es: 1, eb: 1, esat: 0, es8: 1, esat8: 0};
    tbl[5] = '{nb: 2, d: {64'h0, 64'h0, 64'h0, 64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555},
               gaps: 20'h0, es: 64, eb: 2, esat: 0, es8: 64, esat8: 0};

    // reset state
    idle(3);
    check("rst_v_o", vo_a, 0);
    check("rst_sum", sum_a, 0);
    check("rst_beats", beats_a, 0);
    check("rst_sat", sat_a, 0);
    rst = 1'b0;
    idle(1);
    check("rst_ready", rdy_a, 1);

    // single-beat latency: v_o rises after the second edge
    c0 = n_consumed;
    v_i = 1'b1; data = 64'hFFFF_0000_0000_000F; last = 1'b1;
    @(posedge clk); #1;
    v_i = 1'b0; last = 1'b0;
    check("lat_v_o_early", vo_a, 0);
    @(posedge clk); #1;
    check("lat_v_o", vo_a, 1);
    check("lat_sum", sum_a, 20);
    check("lat_beats", beats_a, 1);
    check("lat_sat", sat_a, 0);
    wait_result(c0 + 1);
    idle(2);
    check("lat_v_o_drop", vo_a, 0);
    check("lat_sum_kept", sum_a, 20);

    // table-driven packets
    for (int i = 0; i < 6; i++) begin
      c0 = n_consumed;
      for (int j = 0; j < tbl[i].nb; j++) begin
        send_beat(tbl[i].d[j], (j == tbl[i].nb - 1));
        idle(int'(tbl[i].gaps[j]));
      end
      wait_result(c0 + 1);
      check($sformatf("tbl%0d_sum", i), cap_sum_a, tbl[i].es);
      check($sformatf("tbl%0d_beats", i), cap_beats_a, tbl[i].eb);
      check($sformatf("tbl%0d_sat", i), cap_sat_a, tbl[i].esat);
      check($sformatf("tbl%0d_sum8", i), cap_sum_b, tbl[i].es8);
      check($sformatf("tbl%0d_sat8", i), cap_sat_b, tbl[i].esat8);
      idle(3);
      check($sformatf("tbl%0d_single", i), n_consumed, c0 + 1);
    end

    // back-to-back single-beat packets under backpressure
    c0 = n_consumed;
    ready_i = 1'b0;
    send_beat(64'h1, 1'b1);
    send_beat(64'h3, 1'b1);
    v_i = 1'b1; data = 64'h7; last = 1'b1;
    repeat (5) @(negedge clk);
    check("bp_ready_low", rdy_a, 0);
    check("bp_v_o", vo_a, 1);
    check("bp_sum_first", sum_a, 1);
    @(posedge clk); #1;
    ready_i = 1'b1;
    begin
      int t = 0;
      @(negedge clk);
      while (!rdy_a && t < 20) begin
        @(negedge clk);
        t++;
      end
      check("bp_ready_back", rdy_a, 1);
    end
    @(posedge clk); #1;
    v_i = 1'b0; last = 1'b0;
    wait_result(c0 + 3);
    idle(10);
    check("bp_count", n_consumed, c0 + 3);
    check("bp_last_sum", cap_sum_a, 3);

    // reset with a pending result and a partial packet in flight
    ready_i = 1'b0;
    send_beat(64'h3, 1'b1);
    idle(3);
    check("rs_v_before", vo_a, 1);
    send_beat(ones, 1'b0);
    rst = 1'b1;
    #1;
    check("rs_v_async", vo_a, 0);
    check("rs_sum_async", sum_a, 0);
    check("rs_beats_async", beats_a, 0);
    check("rs_v_c_async", vo_c, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    ready_i = 1'b1;
    c0 = n_consumed;
    send_beat(64'hF000_0000_0000_1F0F, 1'b1);
    wait_result(c0 + 1);
    check("rs_sum", cap_sum_a, 13);
    check("rs_beats", cap_beats_a, 1);
    check("rs_sum_c", cap_sum_c, 9);
    check("rs_beats_c", cap_beats_c, 1);
    check("rs_sat_c", cap_sat_c, 0);

    // randomized packets against the reference model
    rand_rdy = 1;
    for (int p = 0; p < 50; p++) begin
      int nb;
      nb = $urandom_range(1, 10);
      for (int j = 0; j < nb; j++) begin
        logic [63:0] d;
        case ($urandom_range(0, 3))
          0:       d = ones;
          1:       d = '0;
          default: d = {$urandom, $urandom};
        endcase
        send_beat(d, (j == nb - 1));
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
      end
    end
    rand_rdy = 0;
    ready_i = 1'b1;
    idle(30);
    check("sb_drained", q.size(), 0);
    check("final_v_o", vo_a, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
